// File: rtl/dma_tcq_arbiter.sv
// rtl/dma_tcq_arbiter.sv - round-robin merge of per-channel PCIe read requests with tag widening and completion routing
module dma_tcq_arbiter #(
  parameter int CHANNELS         = 2,
  parameter int CH_BITS          = 1,
  parameter int RAM_ADDR_WIDTH   = 18,
  parameter int BUS_ADDR_WIDTH   = 32,
  parameter int REQUEST_LEN_BITS = 12,
  parameter int DATA_BITS        = 3,
  parameter int PCIE_TAG_BITS    = 4,
  parameter int MAX_OUTST        = 8
) (
  input  logic                                                 clk,
  input  logic                                                 rst_n,
  input  logic [CHANNELS-1:0]                                  cfg_ch_en,
  input  logic [CHANNELS-1:0]                                  s_tcq_valid,
  output logic [CHANNELS-1:0]                                  s_tcq_ready,
  input  logic [CHANNELS*(RAM_ADDR_WIDTH-DATA_BITS)-1:0]       s_tcq_laddr,
  input  logic [CHANNELS*(BUS_ADDR_WIDTH-DATA_BITS)-1:0]       s_tcq_raddr,
  input  logic [CHANNELS*(REQUEST_LEN_BITS-DATA_BITS)-1:0]     s_tcq_length,
  input  logic [CHANNELS*PCIE_TAG_BITS-1:0]                    s_tcq_tag,
  output logic                                                 m_tcq_valid,
  input  logic                                                 m_tcq_ready,
  output logic [RAM_ADDR_WIDTH-DATA_BITS-1:0]                  m_tcq_laddr,
  output logic [BUS_ADDR_WIDTH-DATA_BITS-1:0]                  m_tcq_raddr,
  output logic [REQUEST_LEN_BITS-DATA_BITS-1:0]                m_tcq_length,
  output logic [CH_BITS+PCIE_TAG_BITS-1:0]                     m_tcq_tag,
  input  logic                                                 s_cpl_valid,
  output logic                                                 s_cpl_ready,
  input  logic [CH_BITS+PCIE_TAG_BITS-1:0]                     s_cpl_tag,
  output logic [CHANNELS-1:0]                                  m_cpl_valid,
  input  logic [CHANNELS-1:0]                                  m_cpl_ready,
  output logic [PCIE_TAG_BITS-1:0]                             m_cpl_tag,
  output logic                                                 busy,
  output logic                                                 err_underflow
);

  localparam int LA_W = RAM_ADDR_WIDTH - DATA_BITS;
  localparam int RA_W = BUS_ADDR_WIDTH - DATA_BITS;
  localparam int LN_W = REQUEST_LEN_BITS - DATA_BITS;
  localparam int GT_W = CH_BITS + PCIE_TAG_BITS;
  localparam int OW   = $clog2(MAX_OUTST + 1);

  // Registered state
  logic                     m_valid_q, m_valid_d;
  logic [LA_W-1:0]          m_laddr_q, m_laddr_d;
  logic [RA_W-1:0]          m_raddr_q, m_raddr_d;
  logic [LN_W-1:0]          m_len_q, m_len_d;
  logic [GT_W-1:0]          m_tag_q, m_tag_d;
  logic [CH_BITS-1:0]       rr_ptr_q, rr_ptr_d;
  logic [OW-1:0]            outst_q [CHANNELS];
  logic [OW-1:0]            outst_d [CHANNELS];
  logic                     err_q, err_d;
  logic                     busy_q, busy_d;

  // Combinational helpers
  logic [CHANNELS-1:0]      eligible;
  logic                     grant_any;
  logic [CH_BITS-1:0]       grant_idx;
  logic                     can_load;
  logic                     do_grant;
  logic [CH_BITS-1:0]       cpl_ch;
  logic                     cpl_fire;

  // A channel may compete only if it is requesting, enabled, and below its in-flight cap
  always_comb begin
    eligible = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      eligible[i] = s_tcq_valid[i] && cfg_ch_en[i] && (outst_q[i] < OW'(MAX_OUTST));
    end
  end

  // Round-robin search: walk offsets from the far end so the nearest eligible channel to rr_ptr wins
  always_comb begin
    logic [CH_BITS-1:0] idx;
    idx       = '0;
    grant_any = 1'b0;
    grant_idx = '0;
    for (int k = CHANNELS - 1; k >= 0; k--) begin
      idx = rr_ptr_q + CH_BITS'(k);
      if (eligible[idx]) begin
        grant_any = 1'b1;
        grant_idx = idx;
      end
    end
  end

  // Grant qualification; rst_n gating keeps ready low while reset is held even though it is combinational
  always_comb begin
    can_load = !m_valid_q || m_tcq_ready;
    do_grant = can_load && grant_any && rst_n;
    s_tcq_ready = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      s_tcq_ready[i] = do_grant && (grant_idx == CH_BITS'(i));
    end
  end

  // Completion routing: upper tag bits select the owning channel, lower bits go back as its local tag
  always_comb begin
    cpl_ch      = s_cpl_tag[GT_W-1 -: CH_BITS];
    m_cpl_tag   = s_cpl_tag[PCIE_TAG_BITS-1:0];
    s_cpl_ready = m_cpl_ready[cpl_ch];
    cpl_fire    = s_cpl_valid && s_cpl_ready;
    m_cpl_valid = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      m_cpl_valid[i] = s_cpl_valid && (cpl_ch == CH_BITS'(i));
    end
  end

  // Output register next state: load on grant, otherwise drain when accepted, otherwise hold
  always_comb begin
    m_valid_d = m_valid_q;
    m_laddr_d = m_laddr_q;
    m_raddr_d = m_raddr_q;
    m_len_d   = m_len_q;
    m_tag_d   = m_tag_q;
    rr_ptr_d  = rr_ptr_q;
    if (do_grant) begin
      m_valid_d = 1'b1;
      rr_ptr_d  = grant_idx + CH_BITS'(1);
      for (int i = 0; i < CHANNELS; i++) begin
        if (grant_idx == CH_BITS'(i)) begin
          m_laddr_d = s_tcq_laddr[i*LA_W +: LA_W];
          m_raddr_d = s_tcq_raddr[i*RA_W +: RA_W];
          m_len_d   = s_tcq_length[i*LN_W +: LN_W];
          m_tag_d   = {grant_idx, s_tcq_tag[i*PCIE_TAG_BITS +: PCIE_TAG_BITS]};
        end
      end
    end else if (m_tcq_ready) begin
      m_valid_d = 1'b0;
    end
  end

  // Outstanding counters: grant and completion in the same cycle cancel; a completion at zero saturates and flags underflow
  always_comb begin
    logic inc;
    logic dec;
    logic any_outst;
    inc       = 1'b0;
    dec       = 1'b0;
    any_outst = 1'b0;
    err_d     = err_q;
    for (int i = 0; i < CHANNELS; i++) begin
      inc        = do_grant && (grant_idx == CH_BITS'(i));
      dec        = cpl_fire && (cpl_ch == CH_BITS'(i));
      outst_d[i] = outst_q[i];
      if (inc && !dec) begin
        outst_d[i] = outst_q[i] + OW'(1);
      end else if (dec && !inc) begin
        if (outst_q[i] == '0) begin
          err_d = 1'b1;
        end else begin
          outst_d[i] = outst_q[i] - OW'(1);
        end
      end
      if (outst_d[i] != '0) begin
        any_outst = 1'b1;
      end
    end
    busy_d = m_valid_d || any_outst;
  end

  // State register with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid_q <= 1'b0;
      m_laddr_q <= '0;
      m_raddr_q <= '0;
      m_len_q   <= '0;
      m_tag_q   <= '0;
      rr_ptr_q  <= '0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
        outst_q[i] <= '0;
      end
    end else begin
      m_valid_q <= m_valid_d;
      m_laddr_q <= m_laddr_d;
      m_raddr_q <= m_raddr_d;
      m_len_q   <= m_len_d;
      m_tag_q   <= m_tag_d;
      rr_ptr_q  <= rr_ptr_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
      for (int i = 0; i < CHANNELS; i++) begin
        outst_q[i] <= outst_d[i];
      end
    end
  end

  assign m_tcq_valid   = m_valid_q;
  assign m_tcq_laddr   = m_laddr_q;
  assign m_tcq_raddr   = m_raddr_q;
  assign m_tcq_length  = m_len_q;
  assign m_tcq_tag     = m_tag_q;
  assign busy          = busy_q;
  assign err_underflow = err_q;

endmodule

// File: doc/dma_tcq_arbiter.md
# dma_tcq_arbiter

Round-robin scheduler that shares one PCIe read-request queue (TCQ) between several DMA TX channels. Each channel issues single-beat read requests tagged from its own private PCIE_TAG_BITS tag space. The arbiter merges these requests onto one registered output and widens the tag with the channel index. It routes each returning completion tag to the channel that owns it, and caps the number of requests each channel may have outstanding.

## Interface
- CHANNELS, 2: number of requesters; power of two, ≥2.
- CH_BITS, 1: log2(CHANNELS).
- RAM_ADDR_WIDTH, 18: local RAM address width (bytes).
- BUS_ADDR_WIDTH, 32: host bus address width (bytes).
- REQUEST_LEN_BITS, 12: request length field width (bytes).
- DATA_BITS, 3: log2 of bus word bytes; all address/length fields drop these LSBs.
- PCIE_TAG_BITS, 4: per-channel tag width.
- MAX_OUTST, 8: maximum in-flight requests per channel, 1..2^PCIE_TAG_BITS.
- clk in 1: single clock.
- rst_n in 1: reset, asynchronous, active-low.
- cfg_ch_en in CHANNELS: per-channel arbitration enable.
- s_tcq_valid in CHANNELS: per-channel request valid.
- s_tcq_ready out CHANNELS: per-channel request ready; one-hot or zero.
- s_tcq_laddr in CHANNELS*(RAM_ADDR_WIDTH-DATA_BITS): packed local addresses; channel i in slice i.
- s_tcq_raddr in CHANNELS*(BUS_ADDR_WIDTH-DATA_BITS): packed host addresses.
- s_tcq_length in CHANNELS*(REQUEST_LEN_BITS-DATA_BITS): packed lengths (words−1).
- s_tcq_tag in CHANNELS*PCIE_TAG_BITS: packed channel-local tags.
- m_tcq_valid out 1: merged request valid (registered).
- m_tcq_ready in 1: downstream accept.
- m_tcq_laddr, m_tcq_raddr, m_tcq_length out: merged fields, same widths as one slice.
- m_tcq_tag out CH_BITS+PCIE_TAG_BITS: {channel, local tag}.
- s_cpl_valid in 1: request termination from PCIe side.
- s_cpl_ready out 1: termination accept.
- s_cpl_tag in CH_BITS+PCIE_TAG_BITS: global tag being released.
- m_cpl_valid out CHANNELS: per-channel termination valid.
- m_cpl_ready in CHANNELS: per-channel termination ready.
- m_cpl_tag out PCIE_TAG_BITS: local tag, shared by all channels.
- busy out 1: an output request is held or any outstanding count is nonzero.
- err_underflow out 1: sticky; a termination arrived for a channel with zero outstanding.

## Operation
- **Eligibility.** Channel i is eligible when s_tcq_valid[i], cfg_ch_en[i], and outst[i] < MAX_OUTST are all true.
- **Output register.** A single entry: m_tcq_valid plus the fields. It can load when empty, or when m_tcq_valid && m_tcq_ready.
- **Grant.** When the register can load and at least one channel is eligible:
  - Grant the first eligible channel found searching from rr_ptr upward, modulo CHANNELS.
  - Drive s_tcq_ready[g] = 1 combinationally; all other s_tcq_ready bits stay 0.
  - Load the register with slice g and tag {g, s_tcq_tag[g]}.
  - Set rr_ptr to g+1 (mod CHANNELS).
- **No grant.** The register drains on m_tcq_ready, and m_tcq_valid falls the next cycle.
- **Outstanding counters.** outst[i] is clog2(MAX_OUTST+1) bits wide.
  - +1 on a grant to i.
  - −1 on a completion handshake for i.
  - Both in the same cycle: unchanged.
  - A decrement at 0: saturates at 0 and sets err_underflow.
- **Completion path.** Combinational routing with c = s_cpl_tag[MSB -: CH_BITS]:
  - m_cpl_valid[c] = s_cpl_valid.
  - m_cpl_tag = s_cpl_tag low bits.
  - s_cpl_ready = m_cpl_ready[c].
- **Enable changes.** Clearing cfg_ch_en[i] blocks new grants to i only. A request already in the output register still issues, and completions for i still route.
- **Reset.** Asynchronous on rst_n low. All of the following are 0 and held at 0 while rst_n is low: m_tcq_valid, s_tcq_ready, rr_ptr, all outst, err_underflow, busy. Fields and tag reset to 0.
- **Reset mid-operation.** A held request is dropped. Completions arriving after reset are ignored for counting; they saturate the counter at 0 and set err_underflow.

## Timing
- Request latency: channel handshake in cycle t → m_tcq_valid in cycle t+1.
- Throughput: one request per cycle while m_tcq_ready stays high.
- Backpressure: m_tcq_ready low with the register full forces s_tcq_ready = 0. Output fields stay stable while m_tcq_valid && !m_tcq_ready.
- Counters: the grant in cycle t is visible in outst at t+1, so a channel with outst = MAX_OUTST−1 gets exactly one more grant.
- Completion path: zero latency. The counter update is visible the next cycle.
- busy: registered OR of m_tcq_valid and all outst ≠ 0.

## Test plan
- **Two-channel fairness.** CHANNELS=2, both valid continuously, m_tcq_ready=1 → grants alternate 0,1,0,1. m_tcq_tag MSB alternates, and one request issues per cycle.
- **Outstanding cap.** MAX_OUTST=8, channel 0 only, no completions → exactly 8 grants, then s_tcq_ready[0]=0. One completion with tag 0x03 → m_cpl_valid[0]=1, m_cpl_tag=3, and a 9th grant the following cycle.
- **Backpressure.** Hold m_tcq_ready=0 for 5 cycles with the register full → fields are unchanged and no s_tcq_ready is asserted. Release → drain and reload happen in the same cycle.
- **Simultaneous events.** Grant and completion to channel 1 in the same cycle with outst[1]=3 → outst[1] stays 3.
- **Disable and underflow.** Clear cfg_ch_en[1] while channel 1 is valid → only channel 0 is granted. A completion for channel 1 with outst=0 → err_underflow=1 and stays 1.
- **Asynchronous reset.** Assert rst_n=0 mid-burst, asynchronous to clk → m_tcq_valid, busy and the counters go to 0 immediately. After release, the first grant goes to channel 0.
